instruction_fetch: RTL and testbench

Fetch stage directly downstream of `program_counter`. It consumes the current `pc` and runs one 32-bit instruction read per `fetch_start` over a req/ack memory port. It holds the fetched word in an instruction register for decode/execute and reports misaligned-address, bus-error and timeout faults. The phase sequencer pulses `fetch_start` once per instruction, before `phase_execute`, and waits for `fetch_done`.

---
 rtl/instruction_fetch.sv | 177 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: one 32-bit instruction read per fetch_start over a req/ack port,
// holding the result in an instruction register and reporting fetch faults.
module instruction_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] pc_i,
    input  logic        fetch_start_i,
    input  logic        flush_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_req_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        fetch_busy_o,
    output logic        fetch_done_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

    localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      CAUSE_NONE  = 2'b00;
    localparam logic [1:0]      CAUSE_MISAL = 2'b01;
    localparam logic [1:0]      CAUSE_BUS   = 2'b10;
    localparam logic [1:0]      CAUSE_TMO   = 2'b11;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [1:0]    cause_q, cause_d;

    logic ack;
    logic timeout;
    logic aligned;

    // ack is only meaningful while a request is outstanding
    assign ack     = mem_ack_i && req_q;
    assign timeout = (cnt_q == CNT_LAST);
    assign aligned = (pc_i[1:0] == 2'b00);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            instr_q <= RESET_INSTR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!flush_i && fetch_start_i && aligned) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
            end
            REQ, DRAIN: begin
                if (ack || timeout) begin
                    state_d = IDLE;
                end else begin
                    state_d = (flush_i || state_q == DRAIN) ? DRAIN : REQ;
                    if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        addr_d  = addr_q;
        req_d   = req_q;
        instr_d = instr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        fault_d = fault_q;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    instr_d = RESET_INSTR;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                end else if (fetch_start_i) begin
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                    if (!aligned) begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISAL;
                    end else begin
                        addr_d = pc_i;
                        req_d  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (flush_i) begin
                    // the bus cycle cannot be cancelled; only the result is dropped
                    instr_d = RESET_INSTR;
                    valid_d = 1'b0;
                    if (ack || timeout) req_d = 1'b0;
                end else if (ack) begin
                    req_d  = 1'b0;
                    done_d = 1'b1;
                    if (mem_err_i) begin
                        valid_d = 1'b0;
                        fault_d = 1'b1;
                        cause_d = CAUSE_BUS;
                    end else begin
                        instr_d = mem_rdata_i;
                        valid_d = 1'b1;
                    end
                end else if (timeout) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                    cause_d = CAUSE_TMO;
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    instr_d = RESET_INSTR;
                    valid_d = 1'b0;
                end
                if (ack || timeout) req_d = 1'b0;
            end
            default: req_d = 1'b0;
        endcase
    end

    assign mem_addr_o    = addr_q;
    assign mem_req_o     = req_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign fetch_busy_o  = busy_q;
    assign fetch_done_o  = done_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random fetches checked
// against a transaction-level model of wait states, flushes and faults.
module tb_instruction_fetch;

    localparam int          T   = 15;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc;
    logic        fetch_start;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fault;
    logic [1:0]  fault_cause;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_instr;
    logic        exp_valid;

    always #5 clk = ~clk;

    instruction_fetch #(.TIMEOUT_CYCLES(T), .RESET_INSTR(NOP)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .pc_i          (pc),
        .fetch_start_i (fetch_start),
        .flush_i       (flush),
        .mem_addr_o    (mem_addr),
        .mem_req_o     (mem_req),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .mem_err_i     (mem_err),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .fetch_busy_o  (fetch_busy),
        .fetch_done_o  (fetch_done),
        .fault_o       (fault),
        .fault_cause_o (fault_cause)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetch at address a. Memory acks on REQ cycle w (0-based), flush is
    // raised on REQ cycle f (-1 = never); a stray fetch_start is fired while busy.
    task automatic do_fetch(input string nm, input logic [31:0] a, input int w,
                            input logic err, input int f, input logic [31:0] data);
        int reqc = 0, donec = 0, done_at = -1, addr_bad = 0, r = 0;
        logic busy1 = 1'b0;
        int exp_req, exp_donec, exp_done_at;
        logic exp_fault;
        logic [1:0] exp_cause;
        logic aligned;
        aligned = (a[1:0] == 2'b00);
        pc = a; mem_rdata = data; fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        for (int n = 1; n <= T + 4; n++) begin
            if (n == 1) busy1 = fetch_busy;
            if (fetch_done) begin
                donec++;
                if (done_at < 0) done_at = n;
            end
            mem_ack = 1'b0; mem_err = 1'b0; flush = 1'b0; fetch_start = 1'b0;
            if (mem_req) begin
                if (mem_addr !== a) addr_bad++;
                if (r == w) begin mem_ack = 1'b1; mem_err = err; end
                if (r == f) flush = 1'b1;
                if (r == 1) begin fetch_start = 1'b1; pc = a ^ 32'h10; end
                r++; reqc++;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0; mem_err = 1'b0; flush = 1'b0; fetch_start = 1'b0;

        if (!aligned) begin
            exp_req = 0; exp_donec = 1; exp_done_at = 1;
            exp_fault = 1'b1; exp_cause = 2'b01; exp_valid = 1'b0;
        end else begin
            exp_req = (w + 1 < T) ? w + 1 : T;
            if (f >= 0) begin
                exp_donec = 0; exp_done_at = -1;
                exp_fault = 1'b0; exp_cause = 2'b00;
                exp_instr = NOP; exp_valid = 1'b0;
            end else begin
                exp_donec = 1;
                exp_done_at = ((w < T - 1) ? w : T - 1) + 2;
                if (w >= T) begin
                    exp_fault = 1'b1; exp_cause = 2'b11; exp_valid = 1'b0;
                end else if (err) begin
                    exp_fault = 1'b1; exp_cause = 2'b10; exp_valid = 1'b0;
                end else begin
                    exp_fault = 1'b0; exp_cause = 2'b00;
                    exp_instr = data; exp_valid = 1'b1;
                end
            end
        end
        check({nm, ".req_cycles"}, 32'(reqc), 32'(exp_req));
        check({nm, ".done_count"}, 32'(donec), 32'(exp_donec));
        check({nm, ".done_cycle"}, 32'(done_at), 32'(exp_done_at));
        check({nm, ".busy"}, {31'd0, busy1}, {31'd0, aligned});
        check({nm, ".addr_bad"}, 32'(addr_bad), 32'd0);
        check({nm, ".fault"}, {31'd0, fault}, {31'd0, exp_fault});
        check({nm, ".cause"}, {30'd0, fault_cause}, {30'd0, exp_cause});
        check({nm, ".instr"}, instr, exp_instr);
        check({nm, ".valid"}, {31'd0, instr_valid}, {31'd0, exp_valid});
    endtask

    initial begin
        int w, f;
        logic mis, err;
        logic [31:0] a;
        rstn = 1'b0; pc = '0; fetch_start = 1'b0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        exp_instr = NOP; exp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.req", {31'd0, mem_req}, 32'd0);
        check("rst.addr", mem_addr, 32'd0);
        check("rst.instr", instr, NOP);
        check("rst.flags", {26'd0, instr_valid, fetch_busy, fetch_done, fault, fault_cause}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        do_fetch("zero_wait", 32'h100, 0, 1'b0, -1, 32'h0050_0093);
        do_fetch("wait3", 32'h104, 3, 1'b0, -1, 32'h1111_2222);
        do_fetch("misaligned", 32'h102, 0, 1'b0, -1, 32'h3333_4444);
        do_fetch("bus_err", 32'h108, 1, 1'b1, -1, 32'h5555_6666);
        do_fetch("timeout", 32'h10C, 1000, 1'b0, -1, 32'h7777_8888);
        do_fetch("ok_after", 32'h110, 2, 1'b0, -1, 32'h9999_AAAA);
        do_fetch("flush_mid", 32'h114, 5, 1'b0, 2, 32'hDEAD_BEEF);
        do_fetch("flush_ack", 32'h118, 1, 1'b0, 1, 32'hCAFE_F00D);
        do_fetch("flush_tmo", 32'h11C, 1000, 1'b0, 3, 32'hBBBB_CCCC);

        // back-to-back: start accepted in the fetch_done cycle
        pc = 32'h200; mem_rdata = 32'hA0A0_A0A0; fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0; mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("b2b.done1", {31'd0, fetch_done}, 32'd1);
        pc = 32'h300; fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        check("b2b.req2", {31'd0, mem_req}, 32'd1);
        check("b2b.addr2", mem_addr, 32'h300);
        check("b2b.instr1", instr, 32'hA0A0_A0A0);
        mem_rdata = 32'hB0B0_B0B0; mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("b2b.instr2", instr, 32'hB0B0_B0B0);
        check("b2b.done2", {31'd0, fetch_done}, 32'd1);

        // flush and start together in IDLE: start dropped
        pc = 32'h400; flush = 1'b1; fetch_start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; fetch_start = 1'b0;
        check("flush_start.req", {31'd0, mem_req}, 32'd0);
        check("flush_start.busy", {31'd0, fetch_busy}, 32'd0);
        check("flush_start.instr", instr, NOP);
        check("flush_start.valid", {31'd0, instr_valid}, 32'd0);
        exp_instr = NOP; exp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("flush_start.done", {31'd0, fetch_done}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            mis = ($urandom_range(0, 4) == 0);
            a = ($urandom() & 32'hFFFF_FFFC) | (mis ? 32'($urandom_range(1, 3)) : 32'd0);
            w = $urandom_range(0, T + 2);
            err = ($urandom_range(0, 2) == 0);
            f = -1;
            if ($urandom_range(0, 3) == 0) f = $urandom_range(0, (w < T - 1) ? w : T - 1);
            do_fetch($sformatf("rnd%0d", i), a, w, err, f, $urandom());
        end

        // reset in the middle of a request
        pc = 32'h500; fetch_start = 1'b1;
        @(posedge clk); #1;
        fetch_start = 1'b0;
        check("rst_mid.req_before", {31'd0, mem_req}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid.req", {31'd0, mem_req}, 32'd0);
        check("rst_mid.addr", mem_addr, 32'd0);
        check("rst_mid.instr", instr, NOP);
        check("rst_mid.flags", {26'd0, instr_valid, fetch_busy, fetch_done, fault, fault_cause}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        exp_instr = NOP; exp_valid = 1'b0;
        @(posedge clk); #1;
        do_fetch("post_rst", 32'h600, 1, 1'b0, -1, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
